// File: rtl/mmu_tlb.sv
// mmu_tlb: fully associative MIPS32 joint TLB with CP0 probe/read/write and registered
// s0 (fetch) / s1 (data) translation ports. Define TLB_RANDOM_EN to enable TLBWR via Random.
module mmu_tlb #(
  parameter int TLBNUM = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s0_req,
  input  logic [31:0]               s0_vaddr,
  output logic                      s0_found,
  output logic [31:0]               s0_paddr,
  output logic                      s0_v,
  output logic [2:0]                s0_c,
  input  logic                      s1_req,
  input  logic [31:0]               s1_vaddr,
  output logic                      s1_found,
  output logic [31:0]               s1_paddr,
  output logic                      s1_v,
  output logic [2:0]                s1_c,
  output logic                      s1_d,
  input  logic                      MEM_IsTLBWI,
  input  logic                      MEM_IsTLBWR,
  input  logic [$clog2(TLBNUM)-1:0] CP0_index,
  input  logic [18:0]               CP0_vpn2,
  input  logic [7:0]                CP0_asid,
  input  logic [19:0]               CP0_pfn0,
  input  logic [2:0]                CP0_c0,
  input  logic                      CP0_d0,
  input  logic                      CP0_v0,
  input  logic                      CP0_g0,
  input  logic [19:0]               CP0_pfn1,
  input  logic [2:0]                CP0_c1,
  input  logic                      CP0_d1,
  input  logic                      CP0_v1,
  input  logic                      CP0_g1,
  output logic                      MMU_s1found,
  output logic [$clog2(TLBNUM)-1:0] MMU_index,
  output logic [18:0]               MMU_vpn2,
  output logic [7:0]                MMU_asid,
  output logic [19:0]               MMU_pfn0,
  output logic [2:0]                MMU_c0,
  output logic                      MMU_d0,
  output logic                      MMU_v0,
  output logic                      MMU_g0,
  output logic [19:0]               MMU_pfn1,
  output logic [2:0]                MMU_c1,
  output logic                      MMU_d1,
  output logic                      MMU_v1,
  output logic                      MMU_g1
);
  localparam int IW = $clog2(TLBNUM);

  // Page fields are indexed [entry][page], page 1 = odd page (va[12]=1).
  logic [TLBNUM-1:0][18:0]      e_vpn2;
  logic [TLBNUM-1:0][7:0]       e_asid;
  logic [TLBNUM-1:0]            e_g;
  logic [TLBNUM-1:0][1:0][19:0] e_pfn;
  logic [TLBNUM-1:0][1:0][2:0]  e_c;
  logic [TLBNUM-1:0][1:0]       e_d;
  logic [TLBNUM-1:0][1:0]       e_v;

  logic [TLBNUM-1:0] m0, m1, mp;

  for (genvar i = 0; i < TLBNUM; i++) begin : g_cmp
    logic asid_ok;
    assign asid_ok = e_g[i] | (e_asid[i] == CP0_asid);
    assign m0[i]   = asid_ok & (e_vpn2[i] == s0_vaddr[31:13]);
    assign m1[i]   = asid_ok & (e_vpn2[i] == s1_vaddr[31:13]);
    assign mp[i]   = asid_ok & (e_vpn2[i] == CP0_vpn2);
  end

  // {hit, index}; lowest matching entry wins, index is 0 on a miss.
  function automatic logic [IW:0] pick(input logic [TLBNUM-1:0] m);
    pick = '0;
    for (int i = TLBNUM - 1; i >= 0; i--)
      if (m[i]) pick = {1'b1, IW'(i)};
  endfunction

  logic [IW:0]   h0, h1, hp;
  logic [IW-1:0] i0, i1;
  logic          p0, p1;

  assign h0 = pick(m0);
  assign h1 = pick(m1);
  assign hp = pick(mp);
  assign i0 = h0[IW-1:0];
  assign i1 = h1[IW-1:0];
  assign p0 = s0_vaddr[12];
  assign p1 = s1_vaddr[12];

  assign MMU_s1found = hp[IW];
  assign MMU_index   = hp[IW-1:0];

  assign MMU_vpn2 = e_vpn2[CP0_index];
  assign MMU_asid = e_asid[CP0_index];
  assign MMU_g0   = e_g[CP0_index];
  assign MMU_g1   = e_g[CP0_index];
  assign MMU_pfn0 = e_pfn[CP0_index][0];
  assign MMU_c0   = e_c[CP0_index][0];
  assign MMU_d0   = e_d[CP0_index][0];
  assign MMU_v0   = e_v[CP0_index][0];
  assign MMU_pfn1 = e_pfn[CP0_index][1];
  assign MMU_c1   = e_c[CP0_index][1];
  assign MMU_d1   = e_d[CP0_index][1];
  assign MMU_v1   = e_v[CP0_index][1];

  logic          we;
  logic [IW-1:0] widx;

`ifdef TLB_RANDOM_EN
  logic [IW-1:0] rnd;

  always_ff @(posedge clk or negedge rst)
    if (!rst) rnd <= IW'(TLBNUM - 1);
    else      rnd <= rnd - IW'(1);

  // TLBWI has priority; a coincident TLBWR is dropped.
  assign we   = MEM_IsTLBWI | MEM_IsTLBWR;
  assign widx = MEM_IsTLBWI ? CP0_index : rnd;
`else
  logic unused_tlbwr;
  assign unused_tlbwr = MEM_IsTLBWR;
  assign we           = MEM_IsTLBWI;
  assign widx         = CP0_index;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      e_vpn2 <= '0;
      e_asid <= '0;
      e_g    <= '0;
      e_pfn  <= '0;
      e_c    <= '0;
      e_d    <= '0;
      e_v    <= '0;
    end else if (we) begin
      e_vpn2[widx] <= CP0_vpn2;
      e_asid[widx] <= CP0_asid;
      e_g[widx]    <= CP0_g0 & CP0_g1;
      e_pfn[widx]  <= {CP0_pfn1, CP0_pfn0};
      e_c[widx]    <= {CP0_c1, CP0_c0};
      e_d[widx]    <= {CP0_d1, CP0_d0};
      e_v[widx]    <= {CP0_v1, CP0_v0};
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s0_found <= 1'b0;
      s0_paddr <= '0;
      s0_v     <= 1'b0;
      s0_c     <= '0;
      s1_found <= 1'b0;
      s1_paddr <= '0;
      s1_v     <= 1'b0;
      s1_c     <= '0;
      s1_d     <= 1'b0;
    end else begin
      if (s0_req) begin
        s0_found <= h0[IW];
        s0_paddr <= {h0[IW] ? e_pfn[i0][p0] : 20'h0, s0_vaddr[11:0]};
        s0_v     <= h0[IW] & e_v[i0][p0];
        s0_c     <= h0[IW] ? e_c[i0][p0] : 3'd0;
      end
      if (s1_req) begin
        s1_found <= h1[IW];
        s1_paddr <= {h1[IW] ? e_pfn[i1][p1] : 20'h0, s1_vaddr[11:0]};
        s1_v     <= h1[IW] & e_v[i1][p1];
        s1_c     <= h1[IW] ? e_c[i1][p1] : 3'd0;
        s1_d     <= h1[IW] & e_d[i1][p1];
      end
    end
endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: table vectors, directed corner sequences and randomized traffic against
// an entry-list reference model of the TLB.
module tb_mmu_tlb;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic        s0_req = 0, s1_req = 0;
  logic [31:0] s0_vaddr = 0, s1_vaddr = 0;
  logic        s0_found, s1_found, s0_v, s1_v, s1_d;
  logic [31:0] s0_paddr, s1_paddr;
  logic [2:0]  s0_c, s1_c;
  logic        MEM_IsTLBWI = 0, MEM_IsTLBWR = 0;
  logic [3:0]  CP0_index = 0;
  logic [18:0] CP0_vpn2 = 0;
  logic [7:0]  CP0_asid = 0;
  logic [19:0] CP0_pfn0 = 0, CP0_pfn1 = 0;
  logic [2:0]  CP0_c0 = 0, CP0_c1 = 0;
  logic        CP0_d0 = 0, CP0_v0 = 0, CP0_g0 = 0, CP0_d1 = 0, CP0_v1 = 0, CP0_g1 = 0;
  logic        MMU_s1found, MMU_d0, MMU_v0, MMU_g0, MMU_d1, MMU_v1, MMU_g1;
  logic [3:0]  MMU_index;
  logic [18:0] MMU_vpn2;
  logic [7:0]  MMU_asid;
  logic [19:0] MMU_pfn0, MMU_pfn1;
  logic [2:0]  MMU_c0, MMU_c1;

  mmu_tlb dut (
    .clk(clk), .rst(rst),
    .s0_req(s0_req), .s0_vaddr(s0_vaddr), .s0_found(s0_found), .s0_paddr(s0_paddr),
    .s0_v(s0_v), .s0_c(s0_c),
    .s1_req(s1_req), .s1_vaddr(s1_vaddr), .s1_found(s1_found), .s1_paddr(s1_paddr),
    .s1_v(s1_v), .s1_c(s1_c), .s1_d(s1_d),
    .MEM_IsTLBWI(MEM_IsTLBWI), .MEM_IsTLBWR(MEM_IsTLBWR), .CP0_index(CP0_index),
    .CP0_vpn2(CP0_vpn2), .CP0_asid(CP0_asid),
    .CP0_pfn0(CP0_pfn0), .CP0_c0(CP0_c0), .CP0_d0(CP0_d0), .CP0_v0(CP0_v0), .CP0_g0(CP0_g0),
    .CP0_pfn1(CP0_pfn1), .CP0_c1(CP0_c1), .CP0_d1(CP0_d1), .CP0_v1(CP0_v1), .CP0_g1(CP0_g1),
    .MMU_s1found(MMU_s1found), .MMU_index(MMU_index), .MMU_vpn2(MMU_vpn2), .MMU_asid(MMU_asid),
    .MMU_pfn0(MMU_pfn0), .MMU_c0(MMU_c0), .MMU_d0(MMU_d0), .MMU_v0(MMU_v0), .MMU_g0(MMU_g0),
    .MMU_pfn1(MMU_pfn1), .MMU_c1(MMU_c1), .MMU_d1(MMU_d1), .MMU_v1(MMU_v1), .MMU_g1(MMU_g1)
  );

  int nvec = 0, nerr = 0;

  // Reference model: a plain list of entries, searched first-to-last.
  logic [18:0] m_vpn2 [16];
  logic [7:0]  m_asid [16];
  logic        m_g    [16];
  logic [19:0] m_pfn  [16][2];
  logic [2:0]  m_c    [16][2];
  logic        m_d    [16][2];
  logic        m_v    [16][2];
  int          m_rnd;
  logic        e_found [2], e_v [2], e_d [2];
  logic [31:0] e_paddr [2];
  logic [2:0]  e_c [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int mfind(input logic [18:0] vpn2);
    for (int i = 0; i < 16; i++)
      if (m_vpn2[i] == vpn2 && (m_g[i] || m_asid[i] == CP0_asid)) return i;
    return -1;
  endfunction

  task automatic mlook(input int port, input logic [31:0] va);
    int k, p;
    k = mfind(va[31:13]);
    p = int'(va[12]);
    e_found[port] = (k >= 0);
    e_paddr[port] = {(k >= 0) ? m_pfn[k][p] : 20'h0, va[11:0]};
    e_v[port]     = (k >= 0) ? m_v[k][p] : 1'b0;
    e_d[port]     = (k >= 0) ? m_d[k][p] : 1'b0;
    e_c[port]     = (k >= 0) ? m_c[k][p] : 3'd0;
  endtask

  task automatic mwrite(input int k);
    m_vpn2[k] = CP0_vpn2; m_asid[k] = CP0_asid; m_g[k] = CP0_g0 & CP0_g1;
    m_pfn[k][0] = CP0_pfn0; m_c[k][0] = CP0_c0; m_d[k][0] = CP0_d0; m_v[k][0] = CP0_v0;
    m_pfn[k][1] = CP0_pfn1; m_c[k][1] = CP0_c1; m_d[k][1] = CP0_d1; m_v[k][1] = CP0_v1;
  endtask

  task automatic mclear();
    for (int i = 0; i < 16; i++) begin
      m_vpn2[i] = 0; m_asid[i] = 0; m_g[i] = 0;
      for (int p = 0; p < 2; p++) begin
        m_pfn[i][p] = 0; m_c[i][p] = 0; m_d[i][p] = 0; m_v[i][p] = 0;
      end
    end
    for (int p = 0; p < 2; p++) begin
      e_found[p] = 0; e_paddr[p] = 0; e_v[p] = 0; e_d[p] = 0; e_c[p] = 0;
    end
    m_rnd = 15;
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic cycle();
    int pi, ri;
    #1;
    pi = mfind(CP0_vpn2);
    ri = int'(CP0_index);
    chk("probe", {MMU_s1found, MMU_index}, {pi >= 0, (pi < 0) ? 4'd0 : 4'(pi)});
    chk("tlbr_hi", {MMU_vpn2, MMU_asid, MMU_g0, MMU_g1}, {m_vpn2[ri], m_asid[ri], m_g[ri], m_g[ri]});
    chk("tlbr_lo", {MMU_pfn0, MMU_c0, MMU_d0, MMU_v0, MMU_pfn1, MMU_c1, MMU_d1, MMU_v1},
        {m_pfn[ri][0], m_c[ri][0], m_d[ri][0], m_v[ri][0], m_pfn[ri][1], m_c[ri][1], m_d[ri][1], m_v[ri][1]});
    if (s0_req) mlook(0, s0_vaddr);
    if (s1_req) mlook(1, s1_vaddr);
    @(posedge clk);
    if (MEM_IsTLBWI) mwrite(ri);
`ifdef TLB_RANDOM_EN
    else if (MEM_IsTLBWR) mwrite(m_rnd);
    m_rnd = (m_rnd + 15) % 16;
`endif
    #1;
    chk("s0_out", {s0_found, s0_paddr, s0_v, s0_c}, {e_found[0], e_paddr[0], e_v[0], e_c[0]});
    chk("s1_out", {s1_found, s1_paddr, s1_v, s1_c, s1_d}, {e_found[1], e_paddr[1], e_v[1], e_c[1], e_d[1]});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_s0", {s0_found, s0_paddr, s0_v, s0_c}, 64'h0);
    chk("rst_s1", {s1_found, s1_paddr, s1_v, s1_c, s1_d}, 64'h0);
    mclear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic idle();
    s0_req = 0; s1_req = 0; MEM_IsTLBWI = 0; MEM_IsTLBWR = 0;
  endtask

  task automatic set_cp0(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                         input logic g, input logic [19:0] pfn0, input logic [19:0] pfn1);
    CP0_index = idx; CP0_vpn2 = vpn2; CP0_asid = asid; CP0_g0 = g; CP0_g1 = g;
    CP0_pfn0 = pfn0; CP0_c0 = 3'd3; CP0_d0 = 1; CP0_v0 = 1;
    CP0_pfn1 = pfn1; CP0_c1 = 3'd2; CP0_d1 = 0; CP0_v1 = 1;
  endtask

  typedef struct {
    bit          port;
    logic [31:0] va;
    logic [7:0]  asid;
    logic        f;
    logic [31:0] pa;
    logic        v;
    logic        d;
    logic [2:0]  c;
  } vec_t;

  vec_t tbl [6];
  logic [18:0] pool [4];

  initial begin
    logic [31:0] r;
    logic [18:0] wr_exp;

    tbl[0] = '{1'b1, 32'h00400ABC, 8'h05, 1'b1, 32'h12345ABC, 1'b1, 1'b1, 3'd3};
    tbl[1] = '{1'b1, 32'h00401FFF, 8'h05, 1'b1, 32'h0ABCDFFF, 1'b1, 1'b0, 3'd2};
    tbl[2] = '{1'b1, 32'h00400ABC, 8'h06, 1'b0, 32'h00000ABC, 1'b0, 1'b0, 3'd0};
    tbl[3] = '{1'b0, 32'h00400010, 8'h05, 1'b1, 32'h12345010, 1'b1, 1'b0, 3'd3};
    tbl[4] = '{1'b1, 32'h00600123, 8'h05, 1'b0, 32'h00000123, 1'b0, 1'b0, 3'd0};
    tbl[5] = '{1'b0, 32'h00401000, 8'h06, 1'b0, 32'h00000000, 1'b0, 1'b0, 3'd0};
    pool[0] = 19'h00200; pool[1] = 19'h00300; pool[2] = 19'h7FFFF; pool[3] = 19'h00000;

    @(negedge clk);
    do_reset();

    // Lookup on an empty TLB misses and passes the page offset through.
    idle(); s1_req = 1; s1_vaddr = 32'h00401234;
    cycle();
    chk("A_miss", {s1_found, s1_paddr, s1_v, s1_d}, {1'b0, 32'h00000234, 1'b0, 1'b0});

    idle(); set_cp0(4'd3, 19'h00200, 8'h05, 1'b0, 20'h12345, 20'h0ABCD); MEM_IsTLBWI = 1;
    cycle();

    for (int k = 0; k < 6; k++) begin
      idle(); CP0_asid = tbl[k].asid;
      if (tbl[k].port) begin s1_req = 1; s1_vaddr = tbl[k].va; end
      else begin s0_req = 1; s0_vaddr = tbl[k].va; end
      cycle();
      if (tbl[k].port)
        chk($sformatf("tbl%0d_s1", k), {s1_found, s1_paddr, s1_v, s1_d, s1_c},
            {tbl[k].f, tbl[k].pa, tbl[k].v, tbl[k].d, tbl[k].c});
      else
        chk($sformatf("tbl%0d_s0", k), {s0_found, s0_paddr, s0_v, s0_c},
            {tbl[k].f, tbl[k].pa, tbl[k].v, tbl[k].c});
    end

    // Global entry matches regardless of ASID; TLBR reports G on both halves.
    idle(); set_cp0(4'd3, 19'h00200, 8'h05, 1'b1, 20'h12345, 20'h0ABCD); MEM_IsTLBWI = 1;
    cycle();
    idle(); CP0_asid = 8'h06; s1_req = 1; s1_vaddr = 32'h00400ABC;
    cycle();
    chk("C_global_hit", {s1_found, s1_paddr}, {1'b1, 32'h12345ABC});
    chk("C_tlbr_g", {MMU_g0, MMU_g1}, 2'b11);

    // Entries 2 and 7 both match; entry 2 must win for probe and lookup.
    idle(); set_cp0(4'd2, 19'h00200, 8'h06, 1'b0, 20'h22222, 20'h2AAAA); MEM_IsTLBWI = 1;
    cycle();
    idle(); set_cp0(4'd7, 19'h00200, 8'h06, 1'b0, 20'h77777, 20'h7AAAA); MEM_IsTLBWI = 1;
    cycle();
    idle(); CP0_asid = 8'h06; CP0_vpn2 = 19'h00200; s1_req = 1; s1_vaddr = 32'h00400000;
    #1 chk("D_probe", {MMU_s1found, MMU_index}, {1'b1, 4'd2});
    cycle();
    chk("D_lowest", s1_paddr, 32'h22222000);
    s1_vaddr = 32'h00401000;
    cycle();
    chk("D_odd_page", s1_paddr, 32'h2AAAA000);

    // A write is not visible to a lookup in the same cycle.
    idle(); set_cp0(4'd5, 19'h00300, 8'h06, 1'b0, 20'h50505, 20'h55555); MEM_IsTLBWI = 1;
    s0_req = 1; s0_vaddr = 32'h00601000;
    cycle();
    chk("E_same_cycle", s0_found, 1'b0);
    MEM_IsTLBWI = 0;
    cycle();
    chk("E_next_cycle", {s0_found, s0_paddr}, {1'b1, 32'h55555000});

    // Reset in the middle of a pending lookup drops it.
    idle(); s1_req = 1; s1_vaddr = 32'h00400000;
    cycle();
    #2;
    do_reset();
    idle();
    cycle();
    chk("F_cleared", {s1_found, s1_paddr}, 64'h0);

    for (int n = 0; n < 400; n++) begin
      idle();
      r = $urandom();
      CP0_index = r[3:0]; CP0_vpn2 = pool[r[5:4]]; CP0_asid = r[6] ? 8'h05 : 8'h06;
      CP0_g0 = r[7]; CP0_g1 = r[8]; CP0_d0 = r[9]; CP0_v0 = r[10]; CP0_d1 = r[11]; CP0_v1 = r[12];
      CP0_c0 = r[15:13]; CP0_c1 = r[18:16];
      MEM_IsTLBWI = (r[20:19] == 2'b00); MEM_IsTLBWR = (r[22:21] == 2'b00);
      s0_req = r[23]; s1_req = r[24];
      r = $urandom(); CP0_pfn0 = r[19:0]; s0_vaddr = {pool[r[21:20]], r[31:19]};
      r = $urandom(); CP0_pfn1 = r[19:0]; s1_vaddr = {pool[r[21:20]], r[31:19]};
      cycle();
    end

    // Random register: five cycles after reset it points at entry 10, then wraps to 15.
    do_reset();
    idle();
    for (int n = 0; n < 5; n++) cycle();
    set_cp0(4'd0, 19'h01234, 8'h05, 1'b0, 20'h11111, 20'h22222); MEM_IsTLBWR = 1;
    cycle();
    idle(); CP0_index = 4'd10;
`ifdef TLB_RANDOM_EN
    wr_exp = 19'h01234;
`else
    wr_exp = 19'h0;
`endif
    #1 chk("H_wr_e10", MMU_vpn2, wr_exp);
    for (int n = 0; n < 10; n++) cycle();
    CP0_vpn2 = 19'h00555; MEM_IsTLBWR = 1;
    cycle();
    idle(); CP0_index = 4'd15;
`ifdef TLB_RANDOM_EN
    wr_exp = 19'h00555;
`else
    wr_exp = 19'h0;
`endif
    #1 chk("H_wrap_e15", MMU_vpn2, wr_exp);
    // Coincident TLBWI/TLBWR: only entry[CP0_index] changes.
    CP0_index = 4'd1; CP0_vpn2 = 19'h00777; MEM_IsTLBWI = 1; MEM_IsTLBWR = 1;
    cycle();
    idle(); CP0_index = 4'd1;
    #1 chk("H_wi_wins", MMU_vpn2, 19'h00777);
    CP0_index = 4'd14;
    #1 chk("H_wr_dropped", MMU_vpn2, 19'h0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mmu_tlb.md
Name: mmu_tlb

Overview:
- 16-entry, fully associative MIPS32 joint TLB.
- Sits directly downstream of cp0_reg in the MEM stage.
- Consumes CP0 Index/EntryHi/EntryLo0/EntryLo1 for TLBWI, TLBP and TLBR, and returns probe and read results to CP0.
- Also provides two registered translation ports: s0 for instruction fetch and s1 for data access.

Parameters:
- TLBNUM, 16, number of entries. Must be a power of two; index width is log2(TLBNUM) = 4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- s0_req  in  1  instruction lookup request
- s0_vaddr  in  32  instruction virtual address
- s0_found  out  1  registered: s0 hit
- s0_paddr  out  32  registered: {pfn, vaddr[11:0]}
- s0_v  out  1  registered: valid bit of selected page
- s0_c  out  3  registered: cache attribute of selected page
- s1_req  in  1  data lookup request
- s1_vaddr  in  32  data virtual address
- s1_found / s1_paddr / s1_v / s1_c  out  1/32/1/3  same as the s0 outputs, for the data port
- s1_d  out  1  registered: dirty bit of selected page
- MEM_IsTLBWI  in  1  write entry CP0_index
- MEM_IsTLBWR  in  1  write entry Random (see Optional Feature)
- CP0_index  in  4  Index.Index
- CP0_vpn2  in  19  EntryHi.VPN2
- CP0_asid  in  8  EntryHi.ASID
- CP0_pfn0, CP0_c0, CP0_d0, CP0_v0, CP0_g0  in  20,3,1,1,1  EntryLo0 fields
- CP0_pfn1, CP0_c1, CP0_d1, CP0_v1, CP0_g1  in  20,3,1,1,1  EntryLo1 fields
- MMU_s1found  out  1  combinational: probe hit
- MMU_index  out  4  combinational: probe hit index
- MMU_vpn2, MMU_asid  out  19,8  combinational: entry[CP0_index] read for TLBR
- MMU_pfn0, MMU_c0, MMU_d0, MMU_v0, MMU_g0  out  20,3,1,1,1  combinational: entry[CP0_index] even page
- MMU_pfn1, MMU_c1, MMU_d1, MMU_v1, MMU_g1  out  20,3,1,1,1  combinational: entry[CP0_index] odd page

Behaviour:
- Entry storage: vpn2[18:0], asid[7:0], g, pfn0/c0/d0/v0, pfn1/c1/d1/v1.
- On write, stored g = CP0_g0 & CP0_g1.
- Reset (rst=0, asynchronous):
  - All entry fields clear to 0.
  - All registered s0/s1 outputs clear to 0.
  - Random = TLBNUM-1.
- Match rule for entry i: (vpn2_i == va[31:13]) && (g_i || asid_i == CP0_asid).
  - Lookups use the current EntryHi.ASID.
- Page select: va[12]=0 selects page 0 fields; va[12]=1 selects page 1 fields.
- Multiple hits: the lowest matching index wins. This is deterministic; it is not an error.
- Translation ports, 1-cycle latency:
  - At the clk edge with sN_req=1, outputs load the lookup result of sN_vaddr.
  - With sN_req=0, outputs hold their previous value.
  - On a miss: found=0, v=0, d=0, c=0, paddr = {20'b0, vaddr[11:0]}.
- Probe (TLBP):
  - Combinational compare of {CP0_vpn2, CP0_asid} against all entries.
  - MMU_s1found = any hit; MMU_index = hit index, 0 on miss.
  - cp0_reg captures these on its MEM_IsTLBP edge.
- Read (TLBR): MMU_* read fields are a combinational view of entry[CP0_index]. MMU_g0 = MMU_g1 = stored g.
- Write (TLBWI):
  - At the clk edge with MEM_IsTLBWI=1, entry[CP0_index] loads all CP0_* fields.
  - Lookups, probes and reads in the same cycle see the OLD contents; the new contents are visible from the next cycle.
- Simultaneous MEM_IsTLBWI and MEM_IsTLBWR: TLBWI wins and TLBWR is dropped.
- Reset asserted mid-lookup: outputs clear immediately; the pending result is lost.

Optional Feature:
- TLB_RANDOM_EN defined:
  - 4-bit Random counter decrements by 1 every cycle and wraps 0 -> 15.
  - MEM_IsTLBWR=1 writes entry[Random] with the same rule and timing as TLBWI, using the Random value present in that cycle.
- TLB_RANDOM_EN undefined: no counter is implemented and MEM_IsTLBWR is ignored.

Test Plan:
- Reset, then s1_req=1, s1_vaddr=0x00401234 -> next cycle s1_found=0, s1_paddr=0x00000234, s1_v=0, s1_d=0.
- TLBWI index 3, vpn2=0x00200, asid=0x05, g0=g1=0, pfn0=0x12345, v0=1, d0=1, c0=3; CP0_asid=0x05; s1 lookup 0x00400ABC -> s1_found=1, s1_paddr=0x12345ABC, s1_v=1, s1_d=1, s1_c=3.
- Same entry, CP0_asid changed to 0x06 -> miss. Rewrite entry with g0=g1=1 -> hit; TLBR at index 3 returns MMU_g0=MMU_g1=1.
- Entries 2 and 7 both match 0x00400000 with different pfn0; CP0_vpn2=0x00200 -> MMU_s1found=1, MMU_index=2; lookup returns the pfn0 of entry 2.
- TLBWI index 5 and s0 lookup of the same VA in the same cycle -> s0_found=0; the same lookup one cycle later -> s0_found=1. Odd-page VA 0x00401000 returns pfn1.
- With TLB_RANDOM_EN: 5 cycles after reset, assert MEM_IsTLBWR -> entry 10 is written; Random wraps 0 -> 15. Without the macro, MEM_IsTLBWR changes no entry.
